wb_mem_arbiter: RTL

Two-master Wishbone arbiter for the memory bus. It shares the single BusSwitchMem master port between the core BIU (master 0) and a second bus master (master 1, e.g. boot loader or DMA). Arbitration is round-robin and locked per transaction. A watchdog terminates any transaction that the slave does not acknowledge in time.

---
 rtl/wb_mem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter for the memory bus: round-robin grant locked per
// transaction, with a watchdog that terminates transactions the slave never acks.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  output logic              busy_o,
  output logic              gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        state, state_next;
  logic          last, last_next;
  logic          gnt, gnt_next;
  logic [CW-1:0] cnt, cnt_next;

  logic granted;
  logic owner;
  logic own_stb;
  logic timeout_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      last  <= last_next;
      gnt   <= gnt_next;
      cnt   <= cnt_next;
    end
  end

  // Watchdog fires on the TIMEOUT-th granted cycle; a same-cycle ack overrides it.
  always_comb begin
    granted     = (state != IDLE);
    owner       = (state == GNT1);
    own_stb     = owner ? m1_stb_i : m0_stb_i;
    timeout_hit = granted && (cnt == CNT_LIMIT) && !s_ack_i;
  end

  always_comb begin
    state_next = state;
    last_next  = last;
    gnt_next   = gnt;
    cnt_next   = cnt;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_sel_o    = '0;
    m0_dat_o   = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        // On a tie the master that was not served last wins.
        if (m0_stb_i && m1_stb_i) begin
          state_next = last ? GNT0 : GNT1;
          gnt_next   = ~last;
        end else if (m0_stb_i) begin
          state_next = GNT0;
          gnt_next   = 1'b0;
        end else if (m1_stb_i) begin
          state_next = GNT1;
          gnt_next   = 1'b1;
        end
      end
      GNT0, GNT1: begin
        s_stb_o = own_stb && !timeout_hit;
        s_we_o  = owner ? m1_we_i  : m0_we_i;
        s_adr_o = owner ? m1_adr_i : m0_adr_i;
        s_dat_o = owner ? m1_dat_i : m0_dat_i;
        s_sel_o = owner ? m1_sel_i : m0_sel_i;
        if (owner) begin
          m1_dat_o = s_dat_i;
          m1_ack_o = s_ack_i && m1_stb_i;
          m1_err_o = timeout_hit && m1_stb_i;
        end else begin
          m0_dat_o = s_dat_i;
          m0_ack_o = s_ack_i && m0_stb_i;
          m0_err_o = timeout_hit && m0_stb_i;
        end
        if (!own_stb || s_ack_i || timeout_hit) begin
          state_next = IDLE;
          last_next  = owner;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = granted;
  assign gnt_o  = gnt;

endmodule
